// File: rtl/div_unit.sv
// Iterative 32-bit integer divider (DIV/DIVU) with a fixed 33-cycle latency.
// Restoring radix-2 on magnitudes, sign fix-up and divide-by-zero override at the end.
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] div_mag;
    logic [31:0] raw_dividend;
    logic        neg_q, neg_r, zero_div;

    logic        accept, last_step;
    logic [31:0] dividend_mag, divisor_mag;
    logic [32:0] rem_shift, rem_step;
    logic [33:0] diff;
    logic [31:0] quo_step;
    logic [31:0] q_final, r_final;

    // Magnitudes are taken as unsigned so |0x80000000| is 2^31 rather than overflowing.
    assign dividend_mag = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign divisor_mag  = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;

    assign accept    = start && !flush && (state != BUSY);
    assign last_step = (state == BUSY) && (cnt == 6'd31) && !flush;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift = {rem[31:0], quo[31]};
    assign diff      = {1'b0, rem_shift} - {2'b00, div_mag};
    assign rem_step  = diff[33] ? rem_shift : diff[32:0];
    assign quo_step  = {quo[30:0], ~diff[33]};

    always_comb begin
        q_final = neg_q ? (~quo_step + 32'd1) : quo_step;
        r_final = neg_r ? (~rem_step[31:0] + 32'd1) : rem_step[31:0];
        if (zero_div) begin
            q_final = 32'hFFFF_FFFF;
            r_final = raw_dividend;
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    state_next = accept ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 6'd0;
            q           <= 32'd0;
            r           <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            if (accept)
                cnt <= 6'd0;
            else if (state == BUSY)
                cnt <= cnt + 6'd1;
            if (last_step) begin
                q           <= q_final;
                r           <= r_final;
                div_by_zero <= zero_div;
            end
        end
    end

    // NOTE: the working registers carry no reset; they are always loaded on
    // accept before the FSM can consume them.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem          <= 33'd0;
            quo          <= dividend_mag;
            div_mag      <= divisor_mag;
            raw_dividend <= dividend;
            neg_q        <= is_signed && (dividend[31] ^ divisor[31]);
            neg_r        <= is_signed && dividend[31];
            zero_div     <= (divisor == 32'd0);
        end else if (state == BUSY) begin
            rem <= rem_step;
            quo <= quo_step;
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, flush, back-to-back and reset behaviour.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    div_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .q          (q),
        .r          (r),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start pulse and follows the operation, stimulus only.
    // lat = cycle index after acceptance where done was seen (0 if none within 40),
    // busy_ok = busy was high on every cycle before done. Optionally pokes a
    // start with other operands at cycle 'poke' while the divide runs.
    task automatic run_op(input bit no_wait, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input int poke,
                          output int lat, output bit busy_ok);
        if (!no_wait) @(negedge clk);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (poke != 0 && i == poke + 1) start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (poke != 0 && i == poke) begin
                start = 1'b1; is_signed = 1'b0; dividend = 32'd1; divisor = 32'd1;
            end
        end
        start = 1'b0;
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (q !== 32'd0) begin errors++; $display("FAIL reset_q: got %h want 0", q); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_r: got %h want 0", r); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", div_by_zero); end
    endtask

    task automatic test_unsigned;
        int lat; bit bok;
        // start driven in the very first cycle with rst_n released
        rst_n = 1'b1;
        run_op(1'b1, 1'b0, 32'd100, 32'd7, 0, lat, bok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL udiv_latency: got %0d want 33", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL udiv_busy: got %b want 1", bok); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL udiv_busy_at_done: got %b want 0", busy); end
        checks++; if (q !== 32'd14) begin errors++; $display("FAIL udiv_q: got %h want %h", q, 32'd14); end
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL udiv_r: got %h want %h", r, 32'd2); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL udiv_dz: got %b want 0", div_by_zero); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL udiv_done_pulse: got %b want 0", done); end
        run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 0, lat, bok);
        checks++; if (q !== 32'h7FFF_FFFC) begin errors++; $display("FAIL udiv_big_q: got %h want 7ffffffc", q); end
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL udiv_big_r: got %h want 1", r); end
    endtask

    task automatic test_signed;
        int lat; bit bok;
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, bok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL sdiv_latency: got %0d want 33", lat); end
        checks++; if (q !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_neg_q: got %h want fffffffd", q); end
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_neg_r: got %h want ffffffff", r); end
        run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, lat, bok);
        checks++; if (q !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_negdiv_q: got %h want fffffffd", q); end
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL sdiv_negdiv_r: got %h want 1", r); end
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bok);
        checks++; if (q !== 32'h8000_0000) begin errors++; $display("FAIL sdiv_ovf_q: got %h want 80000000", q); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL sdiv_ovf_r: got %h want 0", r); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL sdiv_ovf_dz: got %b want 0", div_by_zero); end
    endtask

    task automatic test_div_zero;
        int lat; bit bok;
        run_op(1'b0, 1'b0, 32'd5, 32'd0, 0, lat, bok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL dz_latency: got %0d want 33", lat); end
        checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_q: got %h want ffffffff", q); end
        checks++; if (r !== 32'd5) begin errors++; $display("FAIL dz_r: got %h want 5", r); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd0, 0, lat, bok);
        checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_signed_q: got %h want ffffffff", q); end
        checks++; if (r !== 32'hFFFF_FFF9) begin errors++; $display("FAIL dz_signed_r: got %h want fffffff9", r); end
        run_op(1'b0, 1'b0, 32'd9, 32'd3, 0, lat, bok);
        checks++; if (q !== 32'd3) begin errors++; $display("FAIL dz_after_q: got %h want 3", q); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL dz_after_r: got %h want 0", r); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_after_flag: got %b want 0", div_by_zero); end
    endtask

    // Previous result is 9/3 = 3 r 0 from test_div_zero.
    task automatic test_flush;
        int n;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);                 // cycle T+1
        start = 1'b0;
        repeat (9) @(negedge clk);      // cycle T+10
        flush = 1'b1;
        @(negedge clk);                 // cycle T+11
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b want 0", done); end
        count_done(40, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", n); end
        checks++; if (q !== 32'd3) begin errors++; $display("FAIL flush_q_hold: got %h want 3", q); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL flush_r_hold: got %h want 0", r); end

        // flush together with start drops the start
        start = 1'b1; flush = 1'b1; dividend = 32'd60; divisor = 32'd6;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b want 0", busy); end
        count_done(40, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL flush_start_no_done: got %0d pulses want 0", n); end

        // flush on the final step (cycle T+32) suppresses done and the update
        start = 1'b1; dividend = 32'd70; divisor = 32'd7;
        @(negedge clk);                 // T+1
        start = 1'b0;
        repeat (31) @(negedge clk);     // T+32
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_last_busy: got %b want 1", busy); end
        flush = 1'b1;
        @(negedge clk);                 // T+33
        flush = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_last_done: got %b want 0", done); end
        count_done(5, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL flush_last_no_done: got %0d pulses want 0", n); end
        checks++; if (q !== 32'd3) begin errors++; $display("FAIL flush_last_q_hold: got %h want 3", q); end
    endtask

    task automatic test_back_to_back;
        int lat; bit bok; int n;
        run_op(1'b0, 1'b0, 32'd20, 32'd4, 0, lat, bok);
        checks++; if (q !== 32'd5) begin errors++; $display("FAIL b2b_first_q: got %h want 5", q); end
        // still in the DONE cycle: start is driven immediately
        run_op(1'b1, 1'b0, 32'd1000, 32'd10, 0, lat, bok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", bok); end
        checks++; if (q !== 32'd100) begin errors++; $display("FAIL b2b_q: got %h want 64", q); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL b2b_r: got %h want 0", r); end

        // start while busy with 1/1 must be ignored
        run_op(1'b0, 1'b0, 32'd77, 32'd7, 5, lat, bok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL busy_start_latency: got %0d want 33", lat); end
        checks++; if (q !== 32'd11) begin errors++; $display("FAIL busy_start_q: got %h want b", q); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL busy_start_r: got %h want 0", r); end
        count_done(40, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL busy_start_extra_done: got %0d pulses want 0", n); end
    endtask

    task automatic test_reset_mid;
        int n;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);                 // T+1
        start = 1'b0;
        repeat (19) @(negedge clk);     // T+20
        rst_n = 1'b0;
        @(negedge clk);                 // T+21
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
        checks++; if (q !== 32'd0) begin errors++; $display("FAIL rstmid_q: got %h want 0", q); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL rstmid_r: got %h want 0", r); end
        count_done(40, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", n); end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be fixed at 32 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a divide this cycle.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 selects DIV, 0 selects DIVU; it is sampled with start.
REQ-006 The block SHALL have port dividend, input, 32 bits: numerator; it is sampled with start.
REQ-007 The block SHALL have port divisor, input, 32 bits: denominator; it is sampled with start.
REQ-008 The block SHALL have port flush, input, 1 bit: abort any operation in progress.
REQ-009 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a single-cycle pulse indicating that q and r are newly valid.
REQ-011 The block SHALL have port q, output, 32 bits: quotient; it feeds the writeback div_q input (LO).
REQ-012 The block SHALL have port r, output, 32 bits: remainder; it feeds the writeback div_r input (HI).
REQ-013 The block SHALL have port div_by_zero, output, 1 bit: set when the last completed divide had divisor == 0.

Function
REQ-014 The block SHALL implement an FSM with three states: IDLE, BUSY and DONE.
REQ-015 In IDLE or DONE, start=1 with flush=0 SHALL be accepted: the FSM goes to BUSY, the iteration counter is cleared, and the operand magnitudes and result signs are latched.
REQ-016 In BUSY, start SHALL be ignored, and the inputs dividend, divisor and is_signed SHALL be don't-care.
REQ-017 Timing SHALL be as follows: for start accepted in cycle T, busy=1 in cycles T+1..T+32, and done=1 with busy=0 in cycle T+33 only. The fixed latency SHALL be 33 cycles, and divisor==0 SHALL not change it.
REQ-018 Each BUSY cycle SHALL perform one restoring radix-2 step on unsigned 32-bit magnitudes, using a 33-bit partial remainder and a 6-bit counter that counts 0..31. Leaving BUSY SHALL occur when the counter equals 31.
REQ-019 For signed operation, magnitudes SHALL be two's-complement absolute values, computed as unsigned so that |0x80000000| = 2^31.
REQ-020 For signed operation, q SHALL be negated when the operand signs differ, and r SHALL take the sign of the dividend.
REQ-021 For unsigned operation, no sign correction SHALL be applied.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give q=0x80000000, r=0, with no flag raised.
REQ-023 When divisor == 0, the results SHALL be forced to q=0xFFFFFFFF and r=dividend (raw, uncorrected), with div_by_zero=1, regardless of is_signed.
REQ-024 q, r and div_by_zero SHALL be registered, SHALL update only on the edge entering DONE, and SHALL hold their values until the next completed divide.
REQ-025 Accepting a new start SHALL NOT clear q, r or div_by_zero.
REQ-026 The DONE state SHALL last exactly one cycle; it SHALL transition to IDLE, or to BUSY if a start is accepted in that cycle (back-to-back operation).
REQ-027 flush=1 in any state SHALL move the FSM to IDLE on the next edge with busy=0 and done=0, and q, r and div_by_zero SHALL be unchanged.
REQ-028 When flush and start are both 1 in the same cycle, flush SHALL win and start SHALL be dropped.
REQ-029 flush=1 in the same cycle as the final BUSY step SHALL suppress done and the result update.
REQ-030 busy SHALL be asserted only in BUSY, and done only in DONE; both SHALL be driven directly from state, with no combinational path from inputs.

Reset
REQ-031 rst_n=0 sampled at an edge SHALL set the state to IDLE, the counter to 0, busy=0, done=0, q=0, r=0 and div_by_zero=0.
REQ-032 Reset SHALL take priority over start and flush, and SHALL abort any operation in progress with no done pulse.
REQ-033 After rst_n returns to 1, a start SHALL be accepted in the first cycle.

Verification
REQ-034 Unsigned divide: start in cycle T with is_signed=0, dividend=100, divisor=7 -> busy in T+1..T+32; in T+33, done=1, q=14, r=2, div_by_zero=0.
REQ-035 Signed divide: is_signed=1, dividend=0xFFFFFFF9 (-7), divisor=2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); then 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
REQ-036 Divide by zero: unsigned 5 / 0 -> done at T+33, q=0xFFFFFFFF, r=5, div_by_zero=1; a following 9 / 3 -> q=3, r=0, div_by_zero=0.
REQ-037 Flush: a divide started at T with flush=1 in T+10 -> busy=0 from T+11, no done pulse, q/r retain the prior result. Also, flush and start in the same cycle -> operation not started.
REQ-038 Back-to-back: start held high in the DONE cycle -> a second divide is accepted and its done appears 33 cycles later. Also, start asserted while busy -> ignored.
REQ-039 Reset mid-operation: rst_n=0 at T+20 -> in the next cycle busy=0, done=0, q=r=0; no done pulse follows.
